// File: rtl/blood_sprite_renderer.sv
// blood_sprite_renderer
//   Read-side client for the 64x64 health-bar sprite ROMs. Maps VGA pixel
//   coordinates to ROM row/col addresses, picks one of six health-level
//   sprites, delays the pixel stream to match the one-cycle ROM latency,
//   keys out the transparent colour and composites over the background.
//   Also animates the displayed health toward the target, one unit every
//   STEP_FRAMES frames.
// Ports:
//   clk, rst_n      pixel clock, async active-low reset
//   x, y, video_on  pixel coordinates and active-display flag
//   frame_start     one-cycle pulse at the start of each frame
//   bg_rgb          background colour aligned with x/y
//   target_health   health requested by game logic (clamped to HEALTH_MAX)
//   rom_row/col     combinational sprite ROM address (0 outside the box)
//   rom_sel         sprite select 0..5 from shown_health
//   rom_color       ROM data, valid the cycle after the address
//   rgb_out         composited pixel, 2 clocks after x/y/bg_rgb
//   shown_health    currently displayed health
//   anim_busy       shown_health differs from clamped target
module blood_sprite_renderer #(
  parameter logic [9:0]  POS_X       = 10'd16,
  parameter logic [9:0]  POS_Y       = 10'd16,
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned SPRITE_H    = 64,
  parameter logic [6:0]  HEALTH_MAX  = 7'd100,
  parameter int unsigned STEP_FRAMES = 4,
  parameter logic [11:0] TRANS_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [11:0] bg_rgb,
  input  logic [6:0]  target_health,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  output logic [2:0]  rom_sel,
  input  logic [11:0] rom_color,
  output logic [11:0] rgb_out,
  output logic [6:0]  shown_health,
  output logic        anim_busy
);

  localparam logic [3:0]  STEP_LAST = 4'(STEP_FRAMES - 1);
  localparam logic [10:0] X_LO = {1'b0, POS_X};
  localparam logic [10:0] Y_LO = {1'b0, POS_Y};
  localparam logic [10:0] X_HI = X_LO + 11'(SPRITE_W);
  localparam logic [10:0] Y_HI = Y_LO + 11'(SPRITE_H);

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

  // Pixel path
  logic        in_box;
  logic [9:0]  dx, dy;
  logic        in_box_q, video_on_q;
  logic [11:0] bg_q, rgb_q, rgb_d;

  assign in_box = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                  ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
  assign dx      = x - POS_X;
  assign dy      = y - POS_Y;
  assign rom_col = in_box ? dx[5:0] : '0;
  assign rom_row = in_box ? dy[5:0] : '0;

  always_comb begin
    rgb_d = bg_q;
    if (!video_on_q)
      rgb_d = '0;
    else if (in_box_q && (rom_color != TRANS_COLOR))
      rgb_d = rom_color;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_q   <= 1'b0;
      video_on_q <= 1'b0;
      bg_q       <= '0;
      rgb_q      <= '0;
    end else begin
      in_box_q   <= in_box;
      video_on_q <= video_on;
      bg_q       <= bg_rgb;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;

  // Health animation
  state_t     state_q, state_d, dir;
  logic [3:0] cnt_q, cnt_d, cnt_cur;
  logic [6:0] health_q, health_d, tgt;

  assign tgt = (target_health > HEALTH_MAX) ? HEALTH_MAX : target_health;

  // The frame that enters (or reverses into) a direction is the first frame
  // of that direction's step interval: the counter is cleared and that same
  // frame is counted, so the first step lands STEP_FRAMES frames after entry
  // counting the entry frame itself.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    health_d = health_q;
    dir      = IDLE;
    cnt_cur  = '0;
    if (frame_start) begin
      if (tgt == health_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        dir     = (tgt < health_q) ? DRAIN : FILL;
        cnt_cur = (dir == state_q) ? cnt_q : '0;
        state_d = dir;
        if (cnt_cur == STEP_LAST) begin
          cnt_d    = '0;
          health_d = (dir == DRAIN) ? health_q - 7'd1 : health_q + 7'd1;
          if (health_d == tgt)
            state_d = IDLE;
        end else begin
          cnt_d = cnt_cur + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      health_q <= HEALTH_MAX;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      health_q <= health_d;
    end
  end

  assign shown_health = health_q;
  assign anim_busy    = (health_q != tgt);
  assign rom_sel = {2'b0, health_q >= 7'd20}  + {2'b0, health_q >= 7'd40} +
                   {2'b0, health_q >= 7'd60}  + {2'b0, health_q >= 7'd80} +
                   {2'b0, health_q >= 7'd100};

endmodule

// File: tb/tb_blood_sprite_renderer.sv
module tb_blood_sprite_renderer;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n;
  logic [9:0]  x, y;
  logic        video_on, frame_start;
  logic [11:0] bg_rgb, rom_color;
  logic [6:0]  target_health;
  logic [5:0]  rom_row, rom_col;
  logic [2:0]  rom_sel;
  logic [11:0] rgb_out;
  logic [6:0]  shown_health;
  logic        anim_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  blood_sprite_renderer #(
    .POS_X(10'd16), .POS_Y(10'd16), .SPRITE_W(64), .SPRITE_H(64),
    .HEALTH_MAX(7'd100), .STEP_FRAMES(4), .TRANS_COLOR(12'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .video_on(video_on),
    .frame_start(frame_start), .bg_rgb(bg_rgb), .target_health(target_health),
    .rom_row(rom_row), .rom_col(rom_col), .rom_sel(rom_sel),
    .rom_color(rom_color), .rgb_out(rgb_out), .shown_health(shown_health),
    .anim_busy(anim_busy)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, supply ROM data a cycle later, check output 2 clocks after x/y.
  task automatic pixel(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic von, input logic [11:0] bg, input logic [11:0] rc,
                       input logic [5:0] erow, input logic [5:0] ecol,
                       input logic [11:0] ergb);
    @(negedge clk);
    x = px; y = py; video_on = von; bg_rgb = bg;
    #1;
    check({tag, "_row"}, {10'd0, rom_row}, {10'd0, erow});
    check({tag, "_col"}, {10'd0, rom_col}, {10'd0, ecol});
    @(posedge clk);
    #1 rom_color = rc;
    @(posedge clk);
    #1 check({tag, "_rgb"}, {4'd0, rgb_out}, {4'd0, ergb});
  endtask

  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; x = '0; y = '0; video_on = 1'b0; frame_start = 1'b0;
    bg_rgb = '0; rom_color = '0; target_health = 7'd100;

    // Reset with clock stopped
    #2 rst_n = 1'b0;
    #2;
    check("rst_rgb",  {4'd0, rgb_out}, 16'h0000);
    check("rst_hp",   {9'd0, shown_health}, 16'd100);
    check("rst_sel",  {13'd0, rom_sel}, 16'd5);
    check("rst_busy", {15'd0, anim_busy}, 16'd0);
    clk_run = 1'b1;
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Pixel path
    pixel("opaque",  10'd21, 10'd23, 1'b1, 12'h00F, 12'hE00, 6'd7,  6'd5,  12'hE00);
    pixel("transp",  10'd21, 10'd23, 1'b1, 12'h00F, 12'h000, 6'd7,  6'd5,  12'h00F);
    pixel("outside", 10'd80, 10'd23, 1'b1, 12'h0A5, 12'hE00, 6'd0,  6'd0,  12'h0A5);
    pixel("left",    10'd15, 10'd40, 1'b1, 12'h123, 12'hE00, 6'd0,  6'd0,  12'h123);
    pixel("corner",  10'd79, 10'd79, 1'b1, 12'h00F, 12'h0F0, 6'd63, 6'd63, 12'h0F0);
    pixel("first",   10'd16, 10'd16, 1'b1, 12'h00F, 12'h321, 6'd0,  6'd0,  12'h321);
    pixel("blank",   10'd21, 10'd23, 1'b0, 12'h00F, 12'hE00, 6'd7,  6'd5,  12'h000);

    // Drain 100 -> 95: one step every 4 frames
    @(negedge clk) target_health = 7'd95;
    #1 check("drn_busy0", {15'd0, anim_busy}, 16'd1);
    frames(3);
    check("drn_f3_hp",  {9'd0, shown_health}, 16'd100);
    check("drn_f3_sel", {13'd0, rom_sel}, 16'd5);
    frame();
    check("drn_f4_hp",  {9'd0, shown_health}, 16'd99);
    check("drn_f4_sel", {13'd0, rom_sel}, 16'd4);
    frames(8);
    check("drn_f12_hp", {9'd0, shown_health}, 16'd97);

    // Reversal to an over-range target, clamped to 100
    target_health = 7'd120;
    frames(11);
    check("rev_f11_hp",   {9'd0, shown_health}, 16'd99);
    check("rev_f11_busy", {15'd0, anim_busy}, 16'd1);
    frame();
    check("rev_f12_hp",   {9'd0, shown_health}, 16'd100);
    check("rev_f12_busy", {15'd0, anim_busy}, 16'd0);
    check("rev_f12_sel",  {13'd0, rom_sel}, 16'd5);
    frames(5);
    check("clamp_hold", {9'd0, shown_health}, 16'd100);

    // Full drain to 95 ending on the 20th frame
    target_health = 7'd95;
    frames(19);
    check("drn_f19_hp",   {9'd0, shown_health}, 16'd96);
    check("drn_f19_busy", {15'd0, anim_busy}, 16'd1);
    frame();
    check("drn_f20_hp",   {9'd0, shown_health}, 16'd95);
    check("drn_f20_busy", {15'd0, anim_busy}, 16'd0);
    frames(4);
    check("drn_idle_hp",  {9'd0, shown_health}, 16'd95);

    // Reset mid-animation
    target_health = 7'd0;
    frames(180);
    check("mid_hp50", {9'd0, shown_health}, 16'd50);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_hp",   {9'd0, shown_health}, 16'd100);
    check("mid_rst_busy", {15'd0, anim_busy}, 16'd1);
    check("mid_rst_rgb",  {4'd0, rgb_out}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    frames(3);
    check("post_f3_hp", {9'd0, shown_health}, 16'd100);
    frame();
    check("post_f4_hp", {9'd0, shown_health}, 16'd99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blood_sprite_renderer.md
Name: blood_sprite_renderer

Overview:
Read-side client for the 64x64 blood/health-bar sprite ROMs (12-bit RGB, registered address, one-cycle read latency). It converts VGA pixel coordinates into sprite row/col addresses and selects one of six health-level sprites. It pipelines the pixel stream to match the ROM latency, keys out the transparent colour and composites the sprite over the incoming background. It also owns the per-frame drain/fill animation that steps the displayed health toward the game's target health.

Parameters:
POS_X, 10'd16, left edge of sprite box (pixels)
POS_Y, 10'd16, top edge of sprite box (pixels)
SPRITE_W, 64, sprite width; col address is 6 bits
SPRITE_H, 64, sprite height; row address is 6 bits
HEALTH_MAX, 7'd100, full health; the reset value of shown_health
STEP_FRAMES, 4, number of frames per 1-unit health step (legal range 1..15)
TRANS_COLOR, 12'h000, ROM colour treated as transparent

Ports:
clk  in  1  system pixel clock
rst_n  in  1  asynchronous active-low reset
x  in  10  current pixel column
y  in  10  current pixel row
video_on  in  1  active display region
frame_start  in  1  one-cycle pulse at start of each frame
bg_rgb  in  12  background colour for the current pixel (aligned with x/y)
target_health  in  7  health requested by game logic
rom_row  out  6  sprite ROM row address (combinational)
rom_col  out  6  sprite ROM col address (combinational)
rom_sel  out  3  sprite select 0..5 (ROM mux select)
rom_color  in  12  selected ROM data, valid the cycle after the address
rgb_out  out  12  composited pixel (registered)
shown_health  out  7  currently displayed health
anim_busy  out  1  high while shown_health != clamped target

Behaviour:
- Reset values (async, rst_n low): rgb_out=0, shown_health=HEALTH_MAX, anim_busy=0, FSM=IDLE, frame counter=0, all pipeline registers=0.
- in_box = (x>=POS_X)&&(x<POS_X+SPRITE_W)&&(y>=POS_Y)&&(y<POS_Y+SPRITE_H).
- Use 11-bit compares so that POS+SIZE cannot wrap.
- rom_col=(x-POS_X)[5:0] and rom_row=(y-POS_Y)[5:0] when in_box; both are 0 otherwise.
- Stage 1 (edge t): the ROM captures the address. The block registers in_box_d, video_on_d and bg_d.
- Stage 2 (edge t+1): rgb_out is registered from rom_color and the stage-1 values.
- Total latency from x/y/bg_rgb to rgb_out is 2 clocks.
- Compositing rule:
  - if !video_on_d: rgb_out=0
  - else if in_box_d && rom_color!=TRANS_COLOR: rgb_out=rom_color
  - else: rgb_out=bg_d
- rom_sel = count of thresholds {20,40,60,80,100} that are <= shown_health.
  - Examples: 0..19 gives 0, 100 gives 5.
  - rom_sel is combinational from the shown_health register.
  - rom_sel is therefore stable within a frame, because shown_health changes only on frame_start.
- tgt = min(target_health, HEALTH_MAX). Target values 101..127 clamp to HEALTH_MAX.
- FSM states: IDLE, DRAIN, FILL. All transitions are evaluated only on cycles with frame_start=1.
  - IDLE: if tgt<shown_health, go to DRAIN; if tgt>shown_health, go to FILL. Frame counter is cleared on entry to either state.
  - DRAIN/FILL: the frame counter increments each frame_start.
  - When the counter reaches STEP_FRAMES-1, shown_health steps by -1 (DRAIN) or +1 (FILL) and the counter clears.
  - If tgt==shown_health (after the step, or because the target changed), return to IDLE.
  - If the target reverses direction mid-animation, switch directly DRAIN<->FILL and clear the counter.
  - shown_health never leaves the range 0..HEALTH_MAX.
- anim_busy is combinational: anim_busy = (shown_health != tgt).
- Changes to target_health between frame_start pulses take effect only at the next frame_start.
- Reset asserted mid-animation restores HEALTH_MAX immediately, independent of clk.
- Reset deasserted mid-frame produces correct pixels starting 2 clocks later.
- frame_start coinciding with a pixel has no effect on that pixel's rgb_out.

Test Plan:
- Reset values: pulse rst_n low with no clock -> rgb_out=0, shown_health=100, rom_sel=5, anim_busy=0.
- Opaque sprite pixel: x=21, y=23, video_on=1, bg=12'h00F, rom_color=12'hE00 one cycle later -> rom_row=7, rom_col=5; rgb_out=12'hE00 two clocks after x/y.
- Transparent and outside pixels:
  - rom_color=12'h000 inside the box -> rgb_out=12'h00F (background).
  - x=80 (outside the box) -> rom_row=rom_col=0, rgb_out=bg.
  - video_on=0 -> rgb_out=0.
- Drain animation: target_health=95 from reset, STEP_FRAMES=4 ->
  - shown_health=99 after the 4th frame_start, so rom_sel goes 5->4;
  - shown_health=95 after the 20th frame_start;
  - anim_busy drops on that same cycle; FSM is IDLE.
- Reversal and clamp:
  - target_health=120 during a drain at shown_health=97 -> FSM enters FILL; after 12 frames shown_health=100; anim_busy=0.
- Reset mid-animation: target_health=0, assert rst_n at shown_health=50 -> shown_health=100 asynchronously; the counter restarts from 0 after release.
